// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage data-memory req/ack access controller
// Optional ack timeout with sticky bus_error enabled by `define MEM_ACCESS_TIMEOUT_EN.
module mem_access_ctrl #(
    parameter int TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  M_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] rdata_out,
    output logic        stall,
    output logic        bus_error
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        is_read_q, is_read_d;
    logic        byte_q, byte_d;
    logic [1:0]  off_q, off_d;
    logic        op;
    logic [31:0] load_aligned;

`ifdef MEM_ACCESS_TIMEOUT_EN
    // Fire on the cycle the counter would step onto all-ones: 2^W-1 REQ cycles total.
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 bus_error_q, bus_error_d;
`endif

    assign op = M_in[0] | M_in[1];

    always_comb begin
        load_aligned = mem_rdata;
        if (byte_q) begin
            case (off_q)
                2'd0:    load_aligned = {24'h0, mem_rdata[7:0]};
                2'd1:    load_aligned = {24'h0, mem_rdata[15:8]};
                2'd2:    load_aligned = {24'h0, mem_rdata[23:16]};
                default: load_aligned = {24'h0, mem_rdata[31:24]};
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        rdata_d     = rdata_q;
        is_read_d   = is_read_q;
        byte_d      = byte_q;
        off_d       = off_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
        cnt_d       = cnt_q;
        bus_error_d = bus_error_q;
`endif
        case (state_q)
            IDLE: begin
                if (op) begin
                    state_d     = REQ;
                    mem_req_d   = 1'b1;
                    mem_we_d    = M_in[0];
                    mem_addr_d  = {addr_in[31:2], 2'b00};
                    mem_be_d    = M_in[2] ? (4'b0001 << addr_in[1:0]) : 4'b1111;
                    mem_wdata_d = M_in[2] ? {4{wdata_in[7:0]}} : wdata_in;
                    // A write wins when both MemRead and MemWrite are set.
                    is_read_d   = M_in[1] & ~M_in[0];
                    byte_d      = M_in[2];
                    off_d       = addr_in[1:0];
`ifdef MEM_ACCESS_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            REQ: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                    if (is_read_q) begin
                        rdata_d = load_aligned;
                    end
                end
`ifdef MEM_ACCESS_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    mem_req_d   = 1'b0;
                    bus_error_d = 1'b1;
                    state_d     = DONE;
                    if (is_read_q) begin
                        rdata_d = 32'h0;
                    end
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_be_q    <= 4'h0;
            rdata_q     <= 32'h0;
            is_read_q   <= 1'b0;
            byte_q      <= 1'b0;
            off_q       <= 2'd0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q       <= '0;
            bus_error_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            rdata_q     <= rdata_d;
            is_read_q   <= is_read_d;
            byte_q      <= byte_d;
            off_q       <= off_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q       <= cnt_d;
            bus_error_q <= bus_error_d;
`endif
        end
    end

    assign stall     = ((state_q == IDLE) & op) | (state_q == REQ);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign rdata_out = rdata_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
    assign bus_error = bus_error_q;
`else
    assign bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  M_in;
    logic [31:0] addr_in, wdata_in;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] rdata_out;
    logic        stall, bus_error;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT_W(4)) dut (
        .clk(clk), .rst(rst), .M_in(M_in), .addr_in(addr_in), .wdata_in(wdata_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .rdata_out(rdata_out), .stall(stall), .bus_error(bus_error)
    );

    int n_cmp = 0;
    int n_fail = 0;

    logic        chk_en = 1'b0;
    logic        exp_req = 1'b0;
    logic        exp_we = 1'b0;
    logic [31:0] exp_addr = 32'h0, exp_wdata = 32'h0;
    logic [3:0]  exp_be = 4'h0;
    logic [31:0] model_rdata = 32'h0;
    logic        model_err = 1'b0;
    logic [31:0] snap_addr, snap_wdata;
    logic [3:0]  snap_be;
    logic        snap_we;
    int          stalls;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] f_be(input logic [2:0] m, input logic [31:0] a);
        return m[2] ? 4'(1 << a[1:0]) : 4'hF;
    endfunction

    function automatic logic [31:0] f_wd(input logic [2:0] m, input logic [31:0] wd);
        return m[2] ? {4{wd[7:0]}} : wd;
    endfunction

    function automatic logic [31:0] f_rd(input logic [2:0] m, input logic [31:0] a,
                                         input logic [31:0] rd);
        int sh;
        sh = 8 * int'(a[1:0]);
        return m[2] ? ((rd >> sh) & 32'hFF) : rd;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req", {31'h0, mem_req}, {31'h0, exp_req});
            chk("rdata_out", rdata_out, model_rdata);
            chk("bus_error", {31'h0, bus_error}, {31'h0, model_err});
            if (exp_req) begin
                chk("bus_addr", mem_addr, exp_addr);
                chk("bus_be", {28'h0, mem_be}, {28'h0, exp_be});
                chk("bus_wdata", mem_wdata, exp_wdata);
                chk("bus_we", {31'h0, mem_we}, {31'h0, exp_we});
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic [2:0] m, input logic [31:0] a, input logic [31:0] wd);
        exp_addr  = {a[31:2], 2'b00};
        exp_be    = f_be(m, a);
        exp_wdata = f_wd(m, wd);
        exp_we    = m[0];
    endtask

    task automatic do_op(input logic [2:0] m, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int wt, output int n_stall);
        set_exp(m, a, wd);
        M_in = m; addr_in = a; wdata_in = wd; mem_ack = 1'b0;
        n_stall = 0;
        @(negedge clk); if (stall) n_stall++;
        step; exp_req = 1'b1;
        for (int i = 0; i < wt; i++) begin
            @(negedge clk); if (stall) n_stall++;
            step;
        end
        mem_ack = 1'b1; mem_rdata = rd;
        @(negedge clk); if (stall) n_stall++;
        snap_addr = mem_addr; snap_be = mem_be; snap_wdata = mem_wdata; snap_we = mem_we;
        step;
        mem_ack = 1'b0; mem_rdata = 32'hDEADBEEF; exp_req = 1'b0;
        if (m[1] && !m[0]) model_rdata = f_rd(m, a, rd);
        @(negedge clk); if (stall) n_stall++;
        step;
        M_in = 3'b000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; M_in = 3'b000; addr_in = 32'h0; wdata_in = 32'h0;
        mem_rdata = 32'h0; mem_ack = 1'b0;
        #12;
        chk("rst_req", {31'h0, mem_req}, 32'h0);
        chk("rst_we", {31'h0, mem_we}, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_be", {28'h0, mem_be}, 32'h0);
        chk("rst_rdata", rdata_out, 32'h0);
        chk("rst_bus_error", {31'h0, bus_error}, 32'h0);
        M_in = 3'b010; #1;
        chk("rst_stall_op", {31'h0, stall}, 32'h1);
        M_in = 3'b000; #1;
        chk("rst_stall_noop", {31'h0, stall}, 32'h0);
        step; rst = 1'b0; chk_en = 1'b1;
        step;

        do_op(3'b010, 32'h100, 32'h0, 32'hCAFEBABE, 0, stalls);
        chk("wl_stalls", stalls, 2);
        chk("wl_addr", snap_addr, 32'h100);
        chk("wl_be", {28'h0, snap_be}, 32'hF);
        chk("wl_we", {31'h0, snap_we}, 32'h0);
        chk("wl_rdata", rdata_out, 32'hCAFEBABE);

        do_op(3'b101, 32'h203, 32'h12345678, 32'h0, 0, stalls);
        chk("bs_addr", snap_addr, 32'h200);
        chk("bs_be", {28'h0, snap_be}, 32'h8);
        chk("bs_wdata", snap_wdata, 32'h78787878);
        chk("bs_we", {31'h0, snap_we}, 32'h1);
        chk("bs_rdata_hold", rdata_out, 32'hCAFEBABE);

        // Back-to-back: the byte load is presented in the IDLE cycle right after DONE.
        do_op(3'b110, 32'h11, 32'h0, 32'hAABBCCDD, 0, stalls);
        chk("bl_be", {28'h0, snap_be}, 32'h2);
        chk("bl_rdata", rdata_out, 32'h000000CC);
        chk("bl_stalls", stalls, 2);

        do_op(3'b010, 32'h40E, 32'h0, 32'h13579BDF, 5, stalls);
        chk("dly_stalls", stalls, 7);
        chk("dly_rdata", rdata_out, 32'h13579BDF);

        do_op(3'b011, 32'h7, 32'hA5A50F0F, 32'h55555555, 1, stalls);
        chk("rw_stalls", stalls, 3);
        chk("rw_we", {31'h0, snap_we}, 32'h1);
        chk("rw_wdata", snap_wdata, 32'hA5A50F0F);
        chk("rw_rdata_hold", rdata_out, 32'h13579BDF);

        step;
        do_op(3'b110, 32'h22, 32'h0, 32'h11223344, 2, stalls);
        chk("bl2_rdata", rdata_out, 32'h00000022);
        chk("bl2_stalls", stalls, 4);

        step;
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("spur_stall", {31'h0, stall}, 32'h0);
        step; mem_ack = 1'b0;
        @(negedge clk);
        chk("spur_req", {31'h0, mem_req}, 32'h0);
        chk("spur_rdata", rdata_out, 32'h00000022);
        step;

`ifdef MEM_ACCESS_TIMEOUT_EN
        set_exp(3'b010, 32'h500, 32'h0);
        M_in = 3'b010; addr_in = 32'h500;
        step; exp_req = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            step;
        end
        exp_req = 1'b0; model_err = 1'b1; model_rdata = 32'h0;
        @(negedge clk);
        chk("to_stall_done", {31'h0, stall}, 32'h0);
        step; M_in = 3'b000;
        step;
        chk("to_bus_error", {31'h0, bus_error}, 32'h1);
        chk("to_rdata", rdata_out, 32'h0);
        do_op(3'b010, 32'h504, 32'h0, 32'h600DCAFE, 0, stalls);
        chk("to_sticky", {31'h0, bus_error}, 32'h1);
`endif

        set_exp(3'b010, 32'h600, 32'h0);
        M_in = 3'b010; addr_in = 32'h600;
        step; exp_req = 1'b1;
        @(negedge clk);
        #2; chk_en = 1'b0; rst = 1'b1;
        #1;
        chk("arst_req", {31'h0, mem_req}, 32'h0);
        chk("arst_stall", {31'h0, stall}, 32'h1);
        chk("arst_rdata", rdata_out, 32'h0);
        chk("arst_bus_error", {31'h0, bus_error}, 32'h0);
        exp_req = 1'b0; model_rdata = 32'h0; model_err = 1'b0;
        step; M_in = 3'b000; rst = 1'b0;
        step; chk_en = 1'b1;
        do_op(3'b010, 32'h604, 32'h0, 32'h0BADF00D, 2, stalls);
        chk("post_rst_stalls", stalls, 4);
        chk("post_rst_rdata", rdata_out, 32'h0BADF00D);
        step;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
